dac_serial_tx: RTL and testbench
================================

Name: dac_serial_tx

Overview:
- Parametrised serial front-end that frames parallel samples into a SYNC/SCLK/DIN stream for the ultrasound transmit DAC chain.
- Takes one multi-channel word per frame through a valid/ready handshake.
- Generates a divided serial clock and an active-low frame sync.
- Shifts NUM_CH daisy-chained channels out back-to-back; successor to the fixed single-channel clk_out/sync_out/din generator.

Parameters:
DATA_W, 16, bits per channel word
NUM_CH, 2, channels per frame (daisy chain); frame length N = NUM_CH*DATA_W bits
CLK_DIV, 4, clk cycles per clk_out half-period (>=1); SCLK = clk/(2*CLK_DIV)
GAP_CYC, 4, minimum clk cycles sync_out stays high between frames (>=1)
MSB_FIRST, 1, 1 = MSB of each channel first; 0 = LSB first

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
s_data  in  NUM_CH*DATA_W  frame word; channel NUM_CH-1 in the top slice, shifted out first
s_valid  in  1  s_data valid
s_ready  out  1  block can accept a frame
clk_out  out  1  serial clock to DAC; idles high, DAC samples on falling edge
sync_out  out  1  active-low frame sync
din  out  1  serial data to DAC
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse when sync_out returns high

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, clk_out=1, sync_out=1, din=0, busy=0, frame_done=0, shift register and counters 0. s_ready = (state==IDLE), so s_ready=1 while in reset.
- All outputs are registered except s_ready.
- Accept occurs on a cycle T with s_valid&&s_ready. s_data is latched; s_data changes after T are ignored.
- FSM states: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- IDLE -> SETUP at accept T:
  - at T+1: sync_out=0, din = first bit (channel NUM_CH-1, MSB or LSB per MSB_FIRST), busy=1.
- SETUP: holds CLK_DIV cycles.
  - First falling edge of clk_out at T+1+CLK_DIV; state becomes SHIFT.
- SHIFT: clk_out toggles every CLK_DIV cycles.
  - Falling edge k (k=0..N-1) at T+1+CLK_DIV*(2k+1).
  - On each rising edge, din advances to the next bit, so din is stable for the full high+low window around each falling edge.
  - Channel boundaries are seamless, with no extra clocks between channels.
- After falling edge N-1, the next rising edge (at T+1+2N*CLK_DIV) coincides with:
  - sync_out=1, din=0, frame_done=1 for that one cycle;
  - state -> GAP.
- GAP: holds GAP_CYC cycles with clk_out=1 and sync_out=1, then IDLE.
  - s_ready=1 again at T+1+2N*CLK_DIV+GAP_CYC.
  - Minimum frame period is 1+2N*CLK_DIV+GAP_CYC cycles.
- Back-to-back: if s_valid is held high, the next accept occurs on the first IDLE cycle. No bubble beyond GAP_CYC plus the IDLE accept cycle.
- s_valid outside IDLE is ignored. No data is lost because s_ready=0, and the source must hold its data.
- Counters:
  - Divider counter width $clog2(CLK_DIV+1); it wraps at CLK_DIV-1.
  - Bit counter width $clog2(N+1); it counts falling edges.
  - Gap counter width $clog2(GAP_CYC+1).
  - CLK_DIV=1: clk_out toggles every clk cycle; the timing formulas above still hold.
- Reset mid-frame: immediate return to reset values. clk_out and sync_out go high asynchronously, terminating the frame; the DAC discards the partial frame. No frame_done is issued.

Decomposition:
- Shared package dac_pkg:
  - state enum (IDLE, SETUP, SHIFT, GAP);
  - default DATA_W/NUM_CH/CLK_DIV/GAP_CYC constants, reused by the receive-side ADC interface.
- One natural sub-module: sclk_divider.
  - Parametrised by CLK_DIV; enable in, clk_out register out.
  - Emits single-cycle fall_tick/rise_tick strobes to the FSM.
- Shift register and FSM stay in dac_serial_tx.

Test Plan:
- Default params, one frame s_data=0xA5C3_0F0F:
  - 32 falling edges;
  - din sampled at the falling edges reads A5C30F0F MSB-first;
  - sync_out low exactly 2*32*4=256 cycles;
  - frame_done is a single pulse;
  - s_ready returns 261 cycles after accept.
- MSB_FIRST=0, NUM_CH=1, DATA_W=8, CLK_DIV=1, s_data=0x01:
  - din=1 at the first falling edge only;
  - sync_out low for 16 cycles.
- s_valid held high for 3 frames (0x1111_2222, 0x3333_4444, 0x5555_6666):
  - three complete frames;
  - sync_out high exactly GAP_CYC=4 cycles between them, plus 1 accept cycle;
  - no data corruption.
- s_data changed and s_valid pulsed while busy:
  - the in-flight frame is unchanged;
  - the second pulse is ignored when s_valid drops before IDLE.
- reset asserted at falling edge 10 of a frame:
  - same cycle: clk_out=1, sync_out=1, din=0, busy=0, s_ready=1;
  - no frame_done;
  - the next accepted frame (0xFFFF_0000) is fully correct.
- CLK_DIV=3, GAP_CYC=1:
  - clk_out high/low phases are exactly 3 cycles each;
  - frame period is 1+192+1=194 cycles.

Source files
------------

// File: rtl/dac_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dac_pkg : shared state encoding and default sizing for DAC/ADC serial links
// Rev 1.0
// ------------------------------------------------------------------
package dac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } state_e;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_NUM_CH  = 2;
   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_GAP_CYC = 4;

endpackage
`default_nettype wire

// File: rtl/sclk_divider.sv
`default_nettype none
// ------------------------------------------------------------------
// sclk_divider : gated serial-clock divider with edge strobes for the framer
// Rev 1.0
// ------------------------------------------------------------------
module sclk_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic clk_out_o,
   output logic fall_tick_o,
   output logic rise_tick_o
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             clk_q;
   logic             wrap;

   // Strobes lead the clk_out edge by one cycle so the FSM updates in step with it.
   assign wrap        = en_i && (cnt_q == CNT_MAX);
   assign fall_tick_o = wrap && clk_q;
   assign rise_tick_o = wrap && !clk_q;
   assign clk_out_o   = clk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         clk_q <= 1'b1;
      end else if (!en_i) begin
         cnt_q <= '0;
         clk_q <= 1'b1;
      end else if (wrap) begin
         cnt_q <= '0;
         clk_q <= ~clk_q;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/dac_serial_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// dac_serial_tx : frames multi-channel samples into a SYNC/SCLK/DIN DAC stream
// Rev 1.0
// ------------------------------------------------------------------
module dac_serial_tx
   import dac_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int GAP_CYC   = DEF_GAP_CYC,
   parameter int MSB_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH*DATA_W-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic                     clk_out,
   output logic                     sync_out,
   output logic                     din,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int N     = NUM_CH * DATA_W;
   localparam int BIT_W = $clog2(N + 1);
   localparam int GAP_W = $clog2(GAP_CYC + 1);

   state_e           state_q;
   logic [N-1:0]     shreg_q;
   logic [BIT_W-1:0] bit_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic             din_q;
   logic             sync_q;
   logic             busy_q;
   logic             done_q;

   logic [N-1:0]     stream;
   logic             accept;
   logic             div_en;
   logic             fall_tick;
   logic             rise_tick;

   // Serial order: bit N-1 of stream leaves first; LSB-first mirrors each channel slice.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      for (genvar b = 0; b < DATA_W; b++) begin : g_bit
         if (MSB_FIRST != 0) begin : g_msb
            assign stream[c*DATA_W + b] = s_data[c*DATA_W + b];
         end else begin : g_lsb
            assign stream[c*DATA_W + DATA_W - 1 - b] = s_data[c*DATA_W + b];
         end
      end
   end

   assign s_ready    = (state_q == IDLE);
   assign accept     = s_valid && s_ready;
   assign div_en     = (state_q == SETUP) || (state_q == SHIFT);
   assign din        = din_q;
   assign sync_out   = sync_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   sclk_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_divider (
      .clk         (clk),
      .rst_n       (reset),
      .en_i        (div_en),
      .clk_out_o   (clk_out),
      .fall_tick_o (fall_tick),
      .rise_tick_o (rise_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         din_q     <= 1'b0;
         sync_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q   <= SETUP;
                  sync_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  din_q     <= stream[N-1];
                  shreg_q   <= stream << 1;
                  bit_cnt_q <= '0;
               end
            end
            SETUP: begin
               if (fall_tick) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= bit_cnt_q + BIT_W'(1);
               end
            end
            SHIFT: begin
               if (fall_tick) begin
                  bit_cnt_q <= bit_cnt_q + BIT_W'(1);
               end else if (rise_tick) begin
                  // The rise after the last falling edge closes the frame.
                  if (bit_cnt_q == BIT_W'(N)) begin
                     state_q   <= GAP;
                     sync_q    <= 1'b1;
                     din_q     <= 1'b0;
                     done_q    <= 1'b1;
                     gap_cnt_q <= '0;
                  end else begin
                     din_q   <= shreg_q[N-1];
                     shreg_q <= shreg_q << 1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  gap_cnt_q <= '0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dac_serial_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dac_serial_tx : directed table bench for three dac_serial_tx configurations
// Rev 1.0
// ------------------------------------------------------------------
module tb_dac_serial_tx;

   typedef struct {
      int          sel;
      logic [31:0] data;
      bit          keep;
      int          glitch;
      logic [31:0] exp_bits;
      int          exp_falls;
      int          exp_low;
      int          exp_lat;
      int          exp_phase;
      int          exp_tail;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] s_data0, s_data2;
   logic [7:0]  s_data1;
   logic        s_valid0, s_valid1, s_valid2;
   logic        s_ready0, s_ready1, s_ready2;
   logic        clk_out0, clk_out1, clk_out2;
   logic        sync0, sync1, sync2;
   logic        din0, din1, din2;
   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;

   int   checks;
   int   errors;
   int   cur_sel;
   logic m_ready, m_clk, m_sync, m_din, m_busy, m_done;

   vec_t vecs[8];

   dac_serial_tx u_dut0 (
      .clk(clk), .reset(rst_n), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
      .clk_out(clk_out0), .sync_out(sync0), .din(din0), .busy(busy0), .frame_done(done0)
   );

   dac_serial_tx #(
      .DATA_W(8), .NUM_CH(1), .CLK_DIV(1), .GAP_CYC(4), .MSB_FIRST(0)
   ) u_dut1 (
      .clk(clk), .reset(rst_n), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
      .clk_out(clk_out1), .sync_out(sync1), .din(din1), .busy(busy1), .frame_done(done1)
   );

   dac_serial_tx #(
      .CLK_DIV(3), .GAP_CYC(1)
   ) u_dut2 (
      .clk(clk), .reset(rst_n), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
      .clk_out(clk_out2), .sync_out(sync2), .din(din2), .busy(busy2), .frame_done(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      m_ready = s_ready0; m_clk = clk_out0; m_sync = sync0;
      m_din   = din0;     m_busy = busy0;   m_done = done0;
      if (cur_sel == 1) begin
         m_ready = s_ready1; m_clk = clk_out1; m_sync = sync1;
         m_din   = din1;     m_busy = busy1;   m_done = done1;
      end else if (cur_sel == 2) begin
         m_ready = s_ready2; m_clk = clk_out2; m_sync = sync2;
         m_din   = din2;     m_busy = busy2;   m_done = done2;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input int sel, input logic v, input logic [31:0] d);
      case (sel)
         0: begin s_data0 = d;      s_valid0 = v; end
         1: begin s_data1 = d[7:0]; s_valid1 = v; end
         default: begin s_data2 = d; s_valid2 = v; end
      endcase
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] bits = '0;
      int c = 0, falls = 0, low = 0, tail = 0, dn = 0, dcyc = 0, lat = 0;
      int run = 0, pmin = 100000, pmax = 0;
      logic prev_clk = 1'b1, prev_sync = 1'b1;
      cur_sel = v.sel;
      set_in(v.sel, 1'b1, v.data);
      #0;
      chk("ready_pre", m_ready, 1);
      @(posedge clk);
      while (lat == 0) begin
         #1;
         c++;
         if (c == 1) begin
            if (!v.keep) set_in(v.sel, 1'b0, v.data);
            chk("sync_c1", m_sync, 0);
            chk("busy_c1", m_busy, 1);
         end
         if (v.glitch != 0 && c == v.glitch)     set_in(v.sel, 1'b1, ~v.data);
         if (v.glitch != 0 && c == v.glitch + 1) set_in(v.sel, 1'b0, ~v.data);
         if (prev_clk && !m_clk) begin
            bits = {bits[30:0], m_din};
            falls++;
         end
         if (!m_sync) low++;
         else if (low > 0) tail++;
         if (m_done) begin dn++; dcyc = c; end
         if (!m_sync) begin
            if (!prev_sync && m_clk == prev_clk) run++;
            else begin
               if (run > 0) begin pmin = (run < pmin) ? run : pmin; pmax = (run > pmax) ? run : pmax; end
               run = 1;
            end
         end else if (!prev_sync) begin
            pmin = (run < pmin) ? run : pmin;
            pmax = (run > pmax) ? run : pmax;
            run  = 0;
         end
         prev_clk  = m_clk;
         prev_sync = m_sync;
         if (m_ready) lat = c;
         else if (c > 4000) begin
            chk("timeout", 1, 0);
            lat = c;
         end else @(posedge clk);
      end
      chk("bits", bits, v.exp_bits);
      chk("falls", falls, v.exp_falls);
      chk("sync_low", low, v.exp_low);
      chk("done_cnt", dn, 1);
      chk("done_cyc", dcyc, v.exp_low + 1);
      chk("ready_lat", lat, v.exp_lat);
      chk("phase_min", pmin, v.exp_phase);
      chk("phase_max", pmax, v.exp_phase);
      chk("gap_tail", tail, v.exp_tail);
      if (v.glitch != 0) begin
         repeat (5) @(posedge clk);
         #1;
         chk("glitch_idle_busy", m_busy, 0);
         chk("glitch_idle_sync", m_sync, 1);
      end
   endtask

   initial begin
      vec_t post;
      int   f, c, dn;
      logic prev;
      checks = 0; errors = 0; cur_sel = 0;
      rst_n = 1'b0;
      s_data0 = '0; s_data1 = '0; s_data2 = '0;
      s_valid0 = 1'b0; s_valid1 = 1'b0; s_valid2 = 1'b0;

      //           sel data          keep glitch exp_bits      falls low  lat  ph tail
      vecs[0] = '{0, 32'hA5C3_0F0F, 1'b0, 0,  32'hA5C3_0F0F, 32, 256, 261, 4, 5};
      vecs[1] = '{0, 32'h1111_2222, 1'b1, 0,  32'h1111_2222, 32, 256, 261, 4, 5};
      vecs[2] = '{0, 32'h3333_4444, 1'b1, 0,  32'h3333_4444, 32, 256, 261, 4, 5};
      vecs[3] = '{0, 32'h5555_6666, 1'b0, 0,  32'h5555_6666, 32, 256, 261, 4, 5};
      vecs[4] = '{0, 32'h1234_5678, 1'b0, 40, 32'h1234_5678, 32, 256, 261, 4, 5};
      vecs[5] = '{1, 32'h0000_0001, 1'b0, 0,  32'h0000_0080, 8,  16,  21,  1, 5};
      vecs[6] = '{1, 32'h0000_0096, 1'b0, 0,  32'h0000_0069, 8,  16,  21,  1, 5};
      vecs[7] = '{2, 32'hC0FF_EE11, 1'b0, 0,  32'hC0FF_EE11, 32, 192, 194, 3, 2};

      #12;
      chk("rst_clk_out", clk_out0, 1);
      chk("rst_sync", sync0, 1);
      chk("rst_din", din0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_ready", s_ready0, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset in the middle of a frame, then a clean frame afterwards.
      cur_sel = 0;
      set_in(0, 1'b1, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 32'hFFFF_FFFF);
      prev = clk_out0; f = 0; c = 0;
      while (f < 10 && c < 2000) begin
         @(posedge clk);
         #1;
         c++;
         if (prev && !clk_out0) f++;
         prev = clk_out0;
      end
      chk("pre_rst_clk", clk_out0, 0);
      chk("pre_rst_sync", sync0, 0);
      chk("pre_rst_din", din0, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_clk_out", clk_out0, 1);
      chk("mid_rst_sync", sync0, 1);
      chk("mid_rst_din", din0, 0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_ready", s_ready0, 1);
      chk("mid_rst_done", done0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done0) dn++;
      end
      chk("post_rst_no_done", dn, 0);
      chk("post_rst_sync", sync0, 1);

      post = '{0, 32'hFFFF_0000, 1'b0, 0, 32'hFFFF_0000, 32, 256, 261, 4, 5};
      run_vec(post);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
